// File: rtl/game_controller.sv
// game_controller
//   Sequencing controller for a 4x4 Connect-4 board register block. Tracks a
//   cursor column from debounced buttons, turns a drop into the index of the
//   lowest empty cell in that column, and decides win / draw / turn change
//   from the board readback after every committed move.
//
// Parameters
//   WRAP_CURSOR : 1 = cursor wraps 3<->0, 0 = cursor saturates at 0 and 3
//   NO_MOVE     : idle value of column_position
//
// Ports
//   clk             system clock, rising edge
//   rst_n           asynchronous active-low reset
//   btn_left        one-cycle pulse: cursor left
//   btn_right       one-cycle pulse: cursor right
//   btn_drop        one-cycle pulse: drop a piece in the cursor column
//   new_game        one-cycle pulse: restart from any state
//   gameboard       occupancy readback, index = row*4 + col, row 0 = bottom
//   players_cells   ownership readback (0 = P1, 1 = P2) where occupied
//   state           00 GAME_INIT, 01 P1_TURN, 10 P2_TURN, 11 END_GAME
//   column_position cell index to write, NO_MOVE when idle
//   cursor          current cursor column
//   winner          00 none, 01 P1, 10 P2, 11 draw (valid in END_GAME)
//   illegal_move    one-cycle pulse: drop into a full column
//   move_count      committed moves, 0-16
module game_controller #(
  parameter bit         WRAP_CURSOR = 1'b1,
  parameter logic [4:0] NO_MOVE     = 5'b11111
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_drop,
  input  logic        new_game,
  input  logic [15:0] gameboard,
  input  logic [15:0] players_cells,
  output logic [1:0]  state,
  output logic [4:0]  column_position,
  output logic [1:0]  cursor,
  output logic [1:0]  winner,
  output logic        illegal_move,
  output logic [4:0]  move_count
);

  typedef enum logic [2:0] {
    PH_INIT,
    PH_WAIT,
    PH_COMMIT,
    PH_CHECK,
    PH_DONE
  } phase_t;

  typedef enum logic [1:0] {
    GAME_INIT = 2'b00,
    P1_TURN   = 2'b01,
    P2_TURN   = 2'b10,
    END_GAME  = 2'b11
  } game_state_t;

  // Cell masks of the ten winning lines: 4 rows, 4 columns, 2 diagonals.
  localparam logic [15:0] WIN_LINES [10] = '{
    16'h000F, 16'h00F0, 16'h0F00, 16'hF000,
    16'h1111, 16'h2222, 16'h4444, 16'h8888,
    16'h8421, 16'h1248
  };

  phase_t      phase;
  game_state_t state_q;
  logic        cur;          // 0 = P1, 1 = P2

  logic [1:0]  drop_row;
  logic        col_full;
  logic        line_win;
  logic [1:0]  cursor_next;
  logic [4:0]  move_count_inc;

  assign state = state_q;

  // Lowest empty row in the cursor column; scanned top-down so the last
  // hit is the lowest one.
  always_comb begin
    drop_row = '0;
    col_full = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      logic [1:0] rr;
      rr = 2'(3 - i);
      if (!gameboard[{rr, cursor}]) begin
        drop_row = rr;
        col_full = 1'b0;
      end
    end
  end

  // A line wins when every cell is occupied and owned by the current player.
  always_comb begin
    line_win = 1'b0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (((gameboard & WIN_LINES[i]) == WIN_LINES[i]) &&
          (((players_cells ^ {16{cur}}) & WIN_LINES[i]) == '0)) begin
        line_win = 1'b1;
      end
    end
  end

  // Simultaneous left and right cancel out.
  always_comb begin
    cursor_next = cursor;
    if (btn_right && !btn_left) begin
      if (cursor != 2'd3 || WRAP_CURSOR) cursor_next = cursor + 2'd1;
    end else if (btn_left && !btn_right) begin
      if (cursor != 2'd0 || WRAP_CURSOR) cursor_next = cursor - 2'd1;
    end
  end

  assign move_count_inc = (move_count == 5'd16) ? move_count : move_count + 5'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase           <= PH_INIT;
      state_q         <= GAME_INIT;
      column_position <= NO_MOVE;
      cursor          <= '0;
      winner          <= '0;
      illegal_move    <= 1'b0;
      move_count      <= '0;
      cur             <= 1'b0;
    end else begin
      illegal_move <= 1'b0;
      if (new_game) begin
        // A write pending in COMMIT still lands this edge; the GAME_INIT
        // cycle that follows makes the board block clear it.
        phase           <= PH_INIT;
        state_q         <= GAME_INIT;
        column_position <= NO_MOVE;
      end else begin
        case (phase)
          PH_INIT: begin
            phase           <= PH_WAIT;
            state_q         <= P1_TURN;
            cur             <= 1'b0;
            cursor          <= '0;
            move_count      <= '0;
            winner          <= '0;
            column_position <= NO_MOVE;
          end
          PH_WAIT: begin
            if (btn_drop) begin
              if (col_full) begin
                illegal_move <= 1'b1;
              end else begin
                column_position <= {1'b0, drop_row, cursor};
                phase           <= PH_COMMIT;
              end
            end else begin
              cursor <= cursor_next;
            end
          end
          PH_COMMIT: begin
            column_position <= NO_MOVE;
            move_count      <= move_count_inc;
            phase           <= PH_CHECK;
          end
          PH_CHECK: begin
            if (line_win) begin
              winner  <= cur ? 2'b10 : 2'b01;
              state_q <= END_GAME;
              phase   <= PH_DONE;
            end else if (move_count == 5'd16) begin
              winner  <= 2'b11;
              state_q <= END_GAME;
              phase   <= PH_DONE;
            end else begin
              cur     <= ~cur;
              state_q <= cur ? P1_TURN : P2_TURN;
              phase   <= PH_WAIT;
            end
          end
          PH_DONE: begin
          end
          default: begin
            phase   <= PH_INIT;
            state_q <= GAME_INIT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_controller.sv
// Self-checking bench for game_controller: a small board register block
// model closes the loop, and a game model (2-D board arrays, turn, count)
// predicts every observed output.
module tb_game_controller;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic        btn_left = 1'b0, btn_right = 1'b0, btn_drop = 1'b0, new_game = 1'b0;
  logic        btn_left2 = 1'b0, btn_right2 = 1'b0, btn_drop2 = 1'b0;
  logic [15:0] gb = '0, pc = '0;
  logic [15:0] gb2 = '0, pc2 = '0;

  logic [1:0]  state, cursor, winner;
  logic [4:0]  column_position, move_count;
  logic        illegal_move;
  logic [1:0]  state2, cursor2, winner2;
  logic [4:0]  column_position2, move_count2;
  logic        illegal_move2;

  game_controller #(.WRAP_CURSOR(1'b1), .NO_MOVE(5'b11111)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_left(btn_left), .btn_right(btn_right), .btn_drop(btn_drop),
    .new_game(new_game), .gameboard(gb), .players_cells(pc),
    .state(state), .column_position(column_position), .cursor(cursor),
    .winner(winner), .illegal_move(illegal_move), .move_count(move_count)
  );

  // Saturating-cursor instance: never drops, only exercises the cursor.
  game_controller #(.WRAP_CURSOR(1'b0), .NO_MOVE(5'b11111)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .btn_left(btn_left2), .btn_right(btn_right2), .btn_drop(btn_drop2),
    .new_game(new_game), .gameboard(gb2), .players_cells(pc2),
    .state(state2), .column_position(column_position2), .cursor(cursor2),
    .winner(winner2), .illegal_move(illegal_move2), .move_count(move_count2)
  );

  // Board register block: clears in GAME_INIT, writes the strobed cell.
  always @(posedge clk) begin
    if (state == 2'b00) begin
      gb <= '0;
      pc <= '0;
    end else if (column_position != 5'b11111) begin
      gb[column_position[3:0]] <= 1'b1;
      pc[column_position[3:0]] <= (state == 2'b10);
    end
  end

  // ---------------- reference model ----------------
  bit occ [4][4];
  bit own [4][4];
  int m_cursor, m_cursor2, m_turn, m_count, m_winner;
  bit m_over;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int turn_code();
    if (m_over) return 3;
    return (m_turn == 0) ? 1 : 2;
  endfunction

  function automatic int lowest_empty(input int col);
    for (int r = 0; r < 4; r++) if (!occ[r][col]) return r;
    return -1;
  endfunction

  function automatic bit model_wins(input int p);
    bit w = 1'b0;
    bit d1 = 1'b1;
    bit d2 = 1'b1;
    for (int a = 0; a < 4; a++) begin
      bit row_ok = 1'b1;
      bit col_ok = 1'b1;
      for (int b = 0; b < 4; b++) begin
        if (!(occ[a][b] && own[a][b] == p)) row_ok = 1'b0;
        if (!(occ[b][a] && own[b][a] == p)) col_ok = 1'b0;
      end
      w = w | row_ok | col_ok;
      if (!(occ[a][a] && own[a][a] == p)) d1 = 1'b0;
      if (!(occ[a][3-a] && own[a][3-a] == p)) d2 = 1'b0;
    end
    return w | d1 | d2;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        occ[r][c] = 1'b0;
        own[r][c] = 1'b0;
      end
    m_cursor = 0; m_cursor2 = 0; m_turn = 0; m_count = 0; m_winner = 0; m_over = 1'b0;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic press(input bit l, input bit r);
    btn_left = l; btn_right = r; btn_left2 = l; btn_right2 = r;
    tick();
    btn_left = 1'b0; btn_right = 1'b0; btn_left2 = 1'b0; btn_right2 = 1'b0;
    if (l != r) begin
      if (r) begin
        if (!m_over) m_cursor = (m_cursor + 1) % 4;
        if (m_cursor2 < 3) m_cursor2++;
      end else begin
        if (!m_over) m_cursor = (m_cursor + 3) % 4;
        if (m_cursor2 > 0) m_cursor2--;
      end
    end
    chk("cursor_wrap", 32'(cursor), m_cursor);
    chk("cursor_sat", 32'(cursor2), m_cursor2);
  endtask

  task automatic move_to(input int col);
    bit go_right;
    if (m_over) begin
      press(1'b0, 1'b1);
      return;
    end
    go_right = 1'($urandom_range(0, 1));
    while (m_cursor != col) press(!go_right, go_right);
  endtask

  task automatic start_game();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    chk("init_state", 32'(state), 0);
    tick();
    model_reset();
    chk("wait_state", 32'(state), 1);
    chk("wait_cursor", 32'(cursor), 0);
    chk("wait_colpos", 32'(column_position), 32'h1F);
    chk("wait_count", 32'(move_count), 0);
    chk("wait_winner", 32'(winner), 0);
  endtask

  task automatic drop(input int col);
    int r;
    move_to(col);
    // Cursor buttons alongside the drop must be ignored.
    btn_left  = 1'($urandom_range(0, 1));
    btn_right = 1'($urandom_range(0, 1));
    btn_drop  = 1'b1;
    tick();
    btn_drop = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    chk("drop_cursor", 32'(cursor), m_cursor);
    if (m_over) begin
      chk("done_state", 32'(state), 3);
      chk("done_colpos", 32'(column_position), 32'h1F);
      chk("done_illegal", 32'(illegal_move), 0);
      tick();
      chk("done_count", 32'(move_count), m_count);
      chk("done_winner", 32'(winner), m_winner);
      return;
    end
    r = lowest_empty(m_cursor);
    if (r < 0) begin
      chk("illegal_pulse", 32'(illegal_move), 1);
      chk("illegal_state", 32'(state), turn_code());
      chk("illegal_colpos", 32'(column_position), 32'h1F);
      tick();
      chk("illegal_clear", 32'(illegal_move), 0);
      chk("illegal_count", 32'(move_count), m_count);
      return;
    end
    chk("commit_colpos", 32'(column_position), r * 4 + m_cursor);
    chk("commit_state", 32'(state), turn_code());
    chk("commit_illegal", 32'(illegal_move), 0);
    occ[r][m_cursor] = 1'b1;
    own[r][m_cursor] = 1'(m_turn);
    m_count++;
    tick();
    chk("check_colpos", 32'(column_position), 32'h1F);
    chk("check_count", 32'(move_count), m_count);
    chk("check_state", 32'(state), turn_code());
    tick();
    if (model_wins(m_turn)) begin
      m_over = 1'b1;
      m_winner = m_turn + 1;
    end else if (m_count == 16) begin
      m_over = 1'b1;
      m_winner = 3;
    end else begin
      m_turn = 1 - m_turn;
    end
    chk("after_state", 32'(state), turn_code());
    chk("after_winner", 32'(winner), m_winner);
    chk("after_count", 32'(move_count), m_count);
  endtask

  task automatic play(input int cols []);
    foreach (cols[i]) drop(cols[i]);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_state", 32'(state), 0);
    chk("rst_colpos", 32'(column_position), 32'h1F);
    chk("rst_cursor", 32'(cursor), 0);
    chk("rst_winner", 32'(winner), 0);
    chk("rst_illegal", 32'(illegal_move), 0);
    chk("rst_count", 32'(move_count), 0);
    #9 rst_n = 1'b1;
    tick();
    chk("post_rst_state", 32'(state), 1);

    // Cursor wrap vs saturate.
    start_game();
    press(1'b0, 1'b1); press(1'b0, 1'b1); press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    press(1'b1, 1'b1);
    press(1'b1, 1'b0); press(1'b1, 1'b0); press(1'b1, 1'b0); press(1'b1, 1'b0);

    // Gravity and full column.
    start_game();
    play('{0, 0, 0, 0, 0});
    chk("full_count", 32'(move_count), 4);

    // Vertical P1 win, then an ignored drop.
    start_game();
    play('{1, 2, 1, 2, 1, 2, 1});
    chk("vert_state", 32'(state), 3);
    chk("vert_winner", 32'(winner), 1);
    chk("vert_count", 32'(move_count), 7);
    drop(3);

    // Anti-diagonal {3,6,9,12} win for P2.
    start_game();
    play('{0, 3, 2, 2, 1, 1, 0, 1, 0, 0});
    chk("diag_winner", 32'(winner), 2);

    // Full board, no line: draw.
    start_game();
    play('{0, 2, 1, 3, 2, 0, 3, 1, 0, 2, 1, 3, 2, 0, 3, 1});
    chk("draw_winner", 32'(winner), 3);
    chk("draw_count", 32'(move_count), 16);

    // new_game during COMMIT: write lands, then the board is cleared.
    start_game();
    move_to(2);
    btn_drop = 1'b1;
    tick();
    btn_drop = 1'b0;
    chk("ng_commit_colpos", 32'(column_position), 2);
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    chk("ng_state", 32'(state), 0);
    chk("ng_colpos", 32'(column_position), 32'h1F);
    chk("ng_write_landed", 32'(gb), 32'h0004);
    tick();
    model_reset();
    chk("ng_board_clear", 32'(gb), 0);
    chk("ng_wait_state", 32'(state), 1);
    chk("ng_count", 32'(move_count), 0);

    // Asynchronous reset in the CHECK cycle.
    drop(0);
    move_to(1);
    btn_drop = 1'b1;
    tick();
    btn_drop = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_state", 32'(state), 0);
    chk("mid_rst_colpos", 32'(column_position), 32'h1F);
    chk("mid_rst_cursor", 32'(cursor), 0);
    chk("mid_rst_winner", 32'(winner), 0);
    chk("mid_rst_illegal", 32'(illegal_move), 0);
    chk("mid_rst_count", 32'(move_count), 0);
    #1 rst_n = 1'b1;
    tick();
    model_reset();
    chk("mid_rst_wait", 32'(state), 1);
    chk("mid_rst_board", 32'(gb), 0);

    // Random games against the model.
    for (int g = 0; g < 6; g++) begin
      start_game();
      for (int k = 0; k < 40 && !m_over; k++) drop(int'($urandom_range(0, 3)));
      drop(int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/game_controller.md
# game_controller

Sequencing controller for the 4x4 Connect-4 board register block. It tracks a cursor column from debounced buttons and turns a drop request into the cell index of the lowest empty cell in that column. It drives the 2-bit game state and 5-bit cell strobe consumed by the board block, reads back the board occupancy and ownership vectors, and decides win, draw or turn change after every committed move.

## Interface
- WRAP_CURSOR, default 1: 1 = the cursor wraps 3<->0; 0 = the cursor saturates at 0 and 3.
- NO_MOVE, default 5'b11111: idle value of `column_position`.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- btn_left  in  1  one-cycle pulse, debounced: cursor left.
- btn_right  in  1  one-cycle pulse, debounced: cursor right.
- btn_drop  in  1  one-cycle pulse, debounced: drop a piece in the cursor column.
- new_game  in  1  one-cycle pulse: restart from any state.
- gameboard  in  16  occupancy readback (1 = occupied); cell index = row*4 + col, row 0 = bottom.
- players_cells  in  16  ownership readback (0 = P1, 1 = P2); valid only where `gameboard` = 1.
- state  out  2  00 GAME_INIT, 01 P1_TURN, 10 P2_TURN, 11 END_GAME.
- column_position  out  5  cell index to write; NO_MOVE when idle.
- cursor  out  2  current cursor column.
- winner  out  2  00 none, 01 P1, 10 P2, 11 draw; valid in END_GAME.
- illegal_move  out  1  one-cycle pulse: drop into a full column.
- move_count  out  5  committed moves, 0-16.

## Operation
- Internal phases: INIT, WAIT, COMMIT, CHECK, DONE. The current player bit `cur` selects P1_TURN or P2_TURN on `state` during WAIT, COMMIT and CHECK.
- Reset values: phase INIT, `state` = 00, `column_position` = NO_MOVE, `cursor` = 0, `winner` = 00, `illegal_move` = 0, `move_count` = 0, `cur` = P1.
- INIT: drive GAME_INIT for exactly one cycle so the board block clears. Then go to WAIT with `cur` = P1, `cursor` = 0, `move_count` = 0, `winner` = 00.
- WAIT:
  - `btn_left` / `btn_right` move the cursor by one.
  - If both are asserted in the same cycle, the cursor is unchanged.
  - `btn_drop` takes priority over cursor movement in the same cycle.
  - On a drop, let r be the lowest row with `gameboard[r*4+cursor]` = 0.
  - If none exists, pulse `illegal_move` for one cycle and stay in WAIT.
  - Otherwise register `column_position` = r*4 + cursor and go to COMMIT.
- COMMIT: lasts one cycle with `column_position` valid. The board block writes the cell on the closing edge. Then `column_position` returns to NO_MOVE, `move_count` increments, and the phase goes to CHECK.
- CHECK: lasts one cycle and evaluates the updated readback.
  - Evaluate 10 lines: 4 rows, 4 columns, diagonals {0,5,10,15} and {3,6,9,12}.
  - A line wins when all 4 cells are occupied and all 4 ownership bits equal `cur`.
  - On a win: `winner` = `cur` + 1, go to DONE.
  - Else if `move_count` = 16: `winner` = 11, go to DONE.
  - Else toggle `cur` and go to WAIT.
- DONE: drive END_GAME. All buttons except `new_game` are ignored.
- `new_game` in any phase goes to INIT on the next edge and overrides every other input. During COMMIT, the pending write still lands, but INIT then clears it.
- Button inputs are ignored in COMMIT and CHECK; there is no queuing.

## Timing
- `btn_drop` is sampled at edge E.
- `column_position` and P1/P2 `state` are valid from E until edge E+1; the board block writes at E+1.
- CHECK evaluates the readback between E+1 and E+2. The next `state` (turn toggle or END_GAME) is visible after E+2.
- Move-to-move latency: 3 cycles minimum.
- `illegal_move` is high for the single cycle after the sampling edge.
- Asynchronous reset mid-move abandons the move. Outputs return to reset values immediately; the next cell write happens only after a new drop.
- `move_count` saturates at 16.

## Test plan
- Reset, then new_game: `state` = 00 for one cycle, then 01; `cursor` = 0, `column_position` = 11111.
- Cursor: with WRAP_CURSOR = 1, 3 x `btn_right` then `btn_right` -> `cursor` = 3 then 0. With WRAP_CURSOR = 0, the same stimulus -> `cursor` stays 3.
- Gravity and full column: P1 col0, P2 col0, P1 col0, P2 col0 -> indices 0, 4, 8, 12. A 5th drop in col0 -> `illegal_move` pulse, `state` unchanged, `move_count` = 4.
- Vertical win: P1 col1, P2 col2, P1 col1, P2 col2, P1 col1, P2 col2, P1 col1 -> `state` = 11, `winner` = 01, `move_count` = 7. A following `btn_drop` has no effect.
- Diagonal win for P2 on {3,6,9,12} -> `winner` = 10. A 16-move fill with no line -> `winner` = 11.
- `new_game` asserted in the COMMIT cycle -> `state` = 00 on the next cycle and the board reads back all zeros; `rst_n` low mid-CHECK -> all outputs immediately at reset values.
